// File: rtl/fp_wb_collector.sv
// fp_wb_collector: round-robin collection of fp_intermediate_wb producers into a small FIFO
// that feeds the normalize/round stage.
package fp_wb_pkg;
    typedef struct packed {
        logic       done;
        logic [3:0] id;
        logic [4:0] rd;
        logic       expo_overflow;
        logic [4:0] fflags;
        logic [2:0] rm;
        logic       carry;
        logic       safe;
        logic       hidden;
        logic [2:0] grs;
        logic [5:0] clz;
        logic       right_shift;
        logic [5:0] right_shift_amt;
        logic       subnormal;
        logic       ignore_max_expo;
        logic       d2s;
    } fp_intermediate_wb_interface_wb_input;

    typedef struct packed {
        logic ack;
    } fp_intermediate_wb_interface_wb_output;
endpackage

module fp_wb_collector
    import fp_wb_pkg::*;
#(
    parameter int NUM_UNITS  = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  fp_intermediate_wb_interface_wb_input  unit_wb_input  [NUM_UNITS],
    output fp_intermediate_wb_interface_wb_output unit_wb_output [NUM_UNITS],
    output logic                                  norm_valid,
    input  logic                                  norm_ready,
    output fp_intermediate_wb_interface_wb_input  norm_data
);
    localparam int PW = $clog2(NUM_UNITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(NUM_UNITS - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic          grant_valid;
    logic          accept;
    logic          pop;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    fp_intermediate_wb_interface_wb_input mem [FIFO_DEPTH];

    function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return PW'(s >= NUM_UNITS ? s - NUM_UNITS : s);
    endfunction

    // Scan from the farthest slot down so the requester nearest the pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (unit_wb_input[rot(ptr, k)].done) begin
                grant_valid = 1'b1;
                grant_idx   = rot(ptr, k);
            end
        end
    end

    // A full buffer blocks accept even if the head pops this cycle.
    assign accept     = grant_valid && (count < FULL) && !rst;
    assign norm_valid = (count != '0) && !rst;
    assign pop        = norm_valid && norm_ready;

    always_comb begin
        norm_data      = mem[head];
        norm_data.done = 1'b1;
    end

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_ack
        assign unit_wb_output[i].ack = accept && (grant_idx == PW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            ptr   <= '0;
        end else begin
            if (accept) begin
                tail <= tail + 1'b1;
                ptr  <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[tail] <= unit_wb_input[grant_idx];
    end
endmodule

// File: tb/tb_fp_wb_collector.sv
// tb_fp_wb_collector: directed vector table plus hand sequences for back-to-back
// transfers and mid-operation reset.
module tb_fp_wb_collector;
    import fp_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic norm_ready = 1'b0;
    logic norm_valid;
    fp_intermediate_wb_interface_wb_input  uin  [3];
    fp_intermediate_wb_interface_wb_output uout [3];
    fp_intermediate_wb_interface_wb_input  nd;
    fp_intermediate_wb_interface_wb_input  all_ones;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_wb_collector #(.NUM_UNITS(3), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .unit_wb_input  (uin),
        .unit_wb_output (uout),
        .norm_valid     (norm_valid),
        .norm_ready     (norm_ready),
        .norm_data      (nd)
    );

    typedef struct {
        logic [2:0] done;
        logic       ready;
        logic [2:0] ack;
        logic       valid;
        logic [3:0] id;
    } vec_t;
    vec_t vt [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] d, input logic r, input logic rs, input logic [3:0] id0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) uin[i].done = d[i];
        uin[0].id  = id0;
        norm_ready = r;
        rst        = rs;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] a, input logic v, input logic [3:0] id);
        chk({tag, "_ack"}, {61'b0, uout[2].ack, uout[1].ack, uout[0].ack}, {61'b0, a});
        chk({tag, "_valid"}, {63'b0, norm_valid}, {63'b0, v});
        if (v) chk({tag, "_id"}, {60'b0, nd.id}, {60'b0, id});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{3'b010, 1'b1, 3'b010, 1'b0, 4'd0};
        vt[1]  = '{3'b000, 1'b1, 3'b000, 1'b1, 4'd2};
        vt[2]  = '{3'b100, 1'b1, 3'b100, 1'b0, 4'd0};
        vt[3]  = '{3'b000, 1'b1, 3'b000, 1'b1, 4'd3};
        vt[4]  = '{3'b111, 1'b1, 3'b001, 1'b0, 4'd0};
        vt[5]  = '{3'b111, 1'b1, 3'b010, 1'b1, 4'd1};
        vt[6]  = '{3'b111, 1'b1, 3'b100, 1'b1, 4'd2};
        vt[7]  = '{3'b111, 1'b1, 3'b001, 1'b1, 4'd3};
        vt[8]  = '{3'b111, 1'b1, 3'b010, 1'b1, 4'd1};
        vt[9]  = '{3'b111, 1'b1, 3'b100, 1'b1, 4'd2};
        vt[10] = '{3'b000, 1'b1, 3'b000, 1'b1, 4'd3};
        vt[11] = '{3'b000, 1'b1, 3'b000, 1'b0, 4'd0};
        vt[12] = '{3'b011, 1'b0, 3'b001, 1'b0, 4'd0};
        vt[13] = '{3'b010, 1'b0, 3'b010, 1'b1, 4'd1};
        vt[14] = '{3'b100, 1'b0, 3'b000, 1'b1, 4'd1};
        vt[15] = '{3'b100, 1'b1, 3'b000, 1'b1, 4'd1};
        vt[16] = '{3'b100, 1'b0, 3'b100, 1'b1, 4'd2};
        vt[17] = '{3'b000, 1'b1, 3'b000, 1'b1, 4'd2};
        vt[18] = '{3'b000, 1'b1, 3'b000, 1'b1, 4'd3};
        vt[19] = '{3'b000, 1'b1, 3'b000, 1'b0, 4'd0};
        for (int i = 0; i < 3; i++) begin
            uin[i]    = '0;
            uin[i].id = 4'(i + 1);
        end
        all_ones = '1;

        drive(3'b111, 1'b1, 1'b1, 4'd1);
        expect_out("reset", 3'b000, 1'b0, 4'd0);
        drive(3'b000, 1'b0, 1'b1, 4'd1);
        expect_out("reset_hold", 3'b000, 1'b0, 4'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].done, vt[i].ready, 1'b0, 4'd1);
            expect_out($sformatf("vec%0d", i), vt[i].ack, vt[i].valid, vt[i].id);
        end

        drive(3'b001, 1'b0, 1'b0, 4'd4);
        expect_out("b2b_fill", 3'b001, 1'b0, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            drive(3'b001, 1'b1, 1'b0, 4'(4 + k));
            expect_out($sformatf("b2b%0d", k), 3'b001, 1'b1, 4'(3 + k));
        end
        drive(3'b000, 1'b1, 1'b0, 4'd1);
        expect_out("b2b_last", 3'b000, 1'b1, 4'd12);
        drive(3'b000, 1'b1, 1'b0, 4'd1);
        expect_out("b2b_empty", 3'b000, 1'b0, 4'd0);

        drive(3'b011, 1'b0, 1'b0, 4'd1);
        expect_out("rst_fill0", 3'b010, 1'b0, 4'd0);
        drive(3'b001, 1'b0, 1'b0, 4'd1);
        expect_out("rst_fill1", 3'b001, 1'b1, 4'd2);
        drive(3'b111, 1'b0, 1'b1, 4'd1);
        expect_out("rst_mid", 3'b000, 1'b0, 4'd0);
        drive(3'b000, 1'b0, 1'b0, 4'd1);
        expect_out("rst_after", 3'b000, 1'b0, 4'd0);
        uin[2]      = '1;
        uin[2].done = 1'b0;
        drive(3'b101, 1'b1, 1'b0, 4'd1);
        expect_out("rst_ptr", 3'b001, 1'b0, 4'd0);
        drive(3'b100, 1'b1, 1'b0, 4'd1);
        expect_out("rst_u2", 3'b100, 1'b1, 4'd1);
        drive(3'b000, 1'b1, 1'b0, 4'd1);
        expect_out("rst_deliver", 3'b000, 1'b1, 4'd15);
        chk("grs", {61'b0, nd.grs}, {61'b0, 3'b111});
        chk("payload", 64'(nd), 64'(all_ones));
        drive(3'b000, 1'b1, 1'b0, 4'd1);
        expect_out("final_empty", 3'b000, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
